paddle_ai_driver: RTL and testbench
===================================

// Module: paddle_ai_driver
// PURPOSE
// - CPU opponent: generates input_up/input_down for the paddle collision controller from ball state.
// - Replaces the human button pair for one paddle; same command interface, opposite end.
// - Tracks the ball while it approaches; returns the paddle to field centre while it recedes.
// PARAMETERS
// - REACT_TICKS  8    game_clk cycles of hesitation after the ball turns toward this paddle
// - DEAD_ZONE    4    |target - paddle centre| <= DEAD_ZONE -> no command (stops oscillation)
// - MOVE_DIV     1    commands issued on 1 of every MOVE_DIV cycles (speed throttle, >=1)
// - BALL_SIZE    8    ball edge length in pixels, used to form the ball centre
// - Y_CENTER     240  y target while the ball recedes
// PORTS
// - game_clk       in   1   game tick clock
// - reset          in   1   synchronous, active-high
// - enable         in   1   1 = AI owns this paddle; 0 = outputs forced low
// - player         in   1   1 = left paddle (x=20), 0 = right paddle (x=600)
// - ball_dir_left  in   1   1 = ball x velocity negative
// - ball_y         in   10  ball top edge
// - paddle_y       in   10  current paddle top edge (fed back from paddle controller)
// - height_paddle  in   8   paddle height in pixels
// - input_up       out  1   registered move-up command
// - input_down     out  1   registered move-down command
// BEHAVIOUR
// - Reset: state=IDLE, input_up=0, input_down=0, react_cnt=0, div_cnt=0; reset wins over all.
// - approaching = player ? ball_dir_left : ~ball_dir_left.
// - FSM states IDLE, CENTER, WAIT, TRACK; enable=0 in any state -> IDLE next cycle, outputs 0.
//   IDLE:   enable=1 -> CENTER.
//   CENTER: target=Y_CENTER; approaching -> WAIT, react_cnt<=REACT_TICKS.
//   WAIT:   outputs 0; ~approaching -> CENTER; else react_cnt==0 -> TRACK, else decrement.
//           Dwell is REACT_TICKS+1 cycles; REACT_TICKS=0 gives a single WAIT cycle.
//   TRACK:  target=ball_y+BALL_SIZE/2 (+offset, see CONFIGURATION); ~approaching -> CENTER.
// - Arithmetic: pc = paddle_y + (height_paddle>>1), 11-bit unsigned; err = target - pc, 12-bit signed.
//   err < -DEAD_ZONE -> up; err > DEAD_ZONE -> down; else neither. err == +/-DEAD_ZONE -> no command.
// - Outputs registered: command reflects inputs sampled one game_clk earlier; up and down never both 1.
// - Throttle: div_cnt counts 0..MOVE_DIV-1, wraps; commands only when div_cnt==0, else 0.
//   div_cnt free-runs in CENTER/TRACK, held 0 in IDLE/WAIT (first command after WAIT is immediate).
// - Direction flip mid-TRACK: CENTER taken next cycle; a new approach restarts the full WAIT dwell.
// - reset mid-WAIT/TRACK: returns to IDLE, pending dwell discarded.
// CONFIGURATION
// - PADDLE_AI_JITTER_EN defined: 8-bit LFSR (x^8+x^6+x^5+x^4+1, seed 8'hA5 on reset) steps every cycle;
//   on WAIT->TRACK latch offset = {lfsr[4:0]} - 16 (signed, -16..+15), added to TRACK target only.
//   Models imperfect aim so the CPU can be beaten.
// - Undefined: offset constant 0, no LFSR logic; TRACK aims exactly at ball centre.
// STRUCTURE
// - pong_pkg: ai_state_t enum, coord_t (10-bit), Y_CENTER/BALL_SIZE defaults shared with ball/paddle blocks.
// - Sub-module lfsr8 (enable-free, sync reset, seed param) instantiated only under PADDLE_AI_JITTER_EN.
// - Rest is one FSM + two counters + comparator in this file.
// TESTING
// - reset=1 for 2 cycles, enable=1 -> up=down=0 during reset; state IDLE then CENTER on cycle after release.
// - CENTER, paddle_y=100, height=64 (pc=132), receding -> input_down=1 each cycle until pc>=236.
// - player=1, ball_dir_left 0->1 -> outputs 0 for 9 cycles (REACT_TICKS=8), TRACK command on 10th.
// - TRACK, ball_y=196 (target 200), pc=196/200/204/205 -> none/none/none/up (DEAD_ZONE=4 boundary).
// - MOVE_DIV=3, TRACK far below -> input_down pattern 1,0,0,1,0,0; enable=0 -> 0 next cycle.
// - JITTER_EN: seed A5, approach -> latched offset matches golden LFSR model; never up&down together.

Source files
------------

// File: rtl/pong_pkg.sv
// Shared types and defaults for the pong game blocks (ball, paddle, AI driver).
// Contents:
//   coord_t     - 10-bit screen coordinate
//   ai_state_t  - CPU opponent FSM state
//   DefYCenter  - vertical field centre in pixels
//   DefBallSize - ball edge length in pixels
//   DefLfsrSeed - aim-jitter LFSR reset seed
package pong_pkg;

  typedef logic [9:0] coord_t;

  typedef enum logic [1:0] {
    StIdle,
    StCenter,
    StWait,
    StTrack
  } ai_state_t;

  localparam int unsigned DefYCenter  = 240;
  localparam int unsigned DefBallSize = 8;
  localparam logic [7:0]  DefLfsrSeed = 8'hA5;

endpackage

// File: rtl/lfsr8.sv
// 8-bit Fibonacci LFSR, polynomial x^8+x^6+x^5+x^4+1, steps every cycle.
// Ports:
//   game_clk - clock
//   reset    - synchronous, active-high; loads SEED
//   lfsr     - current register value
module lfsr8 #(
  parameter logic [7:0] SEED = 8'hA5
) (
  input  logic       game_clk,
  input  logic       reset,
  output logic [7:0] lfsr
);

  logic [7:0] lfsr_q;

  always_ff @(posedge game_clk) begin
    if (reset) begin
      lfsr_q <= SEED;
    end else begin
      lfsr_q <= {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    end
  end

  assign lfsr = lfsr_q;

endmodule

// File: rtl/paddle_ai_driver.sv
// CPU opponent: drives input_up/input_down for one paddle from ball state.
// Tracks the ball centre while it approaches (after a reaction delay) and
// returns the paddle to field centre while it recedes.
// Optional build macro PADDLE_AI_JITTER_EN: adds a random aim offset (-16..+15)
// latched from an 8-bit LFSR each time tracking starts.
// Ports:
//   game_clk      - game tick clock
//   reset         - synchronous, active-high
//   enable        - 1 = AI owns this paddle, 0 = outputs forced low
//   player        - 1 = left paddle, 0 = right paddle
//   ball_dir_left - 1 = ball moving toward smaller x
//   ball_y        - ball top edge
//   paddle_y      - current paddle top edge
//   height_paddle - paddle height in pixels
//   input_up      - registered move-up command
//   input_down    - registered move-down command
module paddle_ai_driver
  import pong_pkg::*;
#(
  parameter int unsigned REACT_TICKS = 8,
  parameter int unsigned DEAD_ZONE   = 4,
  parameter int unsigned MOVE_DIV    = 1,
  parameter int unsigned BALL_SIZE   = DefBallSize,
  parameter int unsigned Y_CENTER    = DefYCenter
) (
  input  logic       game_clk,
  input  logic       reset,
  input  logic       enable,
  input  logic       player,
  input  logic       ball_dir_left,
  input  coord_t     ball_y,
  input  coord_t     paddle_y,
  input  logic [7:0] height_paddle,
  output logic       input_up,
  output logic       input_down
);

  localparam int unsigned CntW = (REACT_TICKS > 0) ? $clog2(REACT_TICKS + 1) : 1;
  localparam int unsigned DivW = (MOVE_DIV > 1) ? $clog2(MOVE_DIV) : 1;

  ai_state_t        state_q, state_d;
  logic [CntW-1:0]  react_cnt_q, react_cnt_d;
  logic [DivW-1:0]  div_cnt_q, div_cnt_d;
  logic             up_q, up_d, down_q, down_d;
  logic signed [5:0] offset;

  logic                approaching;
  logic [10:0]         pc;
  logic signed [11:0]  target, err, dz;
  logic                want_up, want_down;

  assign approaching = player ? ball_dir_left : ~ball_dir_left;

`ifdef PADDLE_AI_JITTER_EN
  logic [7:0]        lfsr;
  logic signed [5:0] offset_q, offset_d;

  lfsr8 #(
    .SEED (DefLfsrSeed)
  ) u_lfsr8 (
    .game_clk (game_clk),
    .reset    (reset),
    .lfsr     (lfsr)
  );

  // Low five LFSR bits minus 16, wrapped in 6 bits, gives a signed -16..+15.
  always_comb begin
    offset_d = offset_q;
    if (state_q == StWait && state_d == StTrack) begin
      offset_d = 6'(lfsr & 8'h1F) - 6'd16;
    end
  end

  always_ff @(posedge game_clk) begin
    if (reset) begin
      offset_q <= '0;
    end else begin
      offset_q <= offset_d;
    end
  end

  assign offset = offset_q;
`else
  assign offset = '0;
`endif

  // Paddle centre and signed aim error.
  assign pc = {1'b0, paddle_y} + {3'b0, (height_paddle >> 1)};

  always_comb begin
    if (state_q == StTrack) begin
      target = $signed({2'b0, ball_y}) + $signed(12'(BALL_SIZE / 2))
             + $signed({{6{offset[5]}}, offset});
    end else begin
      target = $signed(12'(Y_CENTER));
    end
  end

  assign err       = target - $signed({1'b0, pc});
  assign dz        = $signed(12'(DEAD_ZONE));
  assign want_up   = err < -dz;
  assign want_down = err > dz;

  // State register; command outputs are registered alongside.
  always_ff @(posedge game_clk) begin
    if (reset) begin
      state_q     <= StIdle;
      react_cnt_q <= '0;
      div_cnt_q   <= '0;
      up_q        <= 1'b0;
      down_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      react_cnt_q <= react_cnt_d;
      div_cnt_q   <= div_cnt_d;
      up_q        <= up_d;
      down_q      <= down_d;
    end
  end

  // Next-state and counters.
  always_comb begin
    state_d     = state_q;
    react_cnt_d = react_cnt_q;
    div_cnt_d   = '0;
    if (!enable) begin
      state_d     = StIdle;
      react_cnt_d = '0;
    end else begin
      unique case (state_q)
        StIdle: state_d = StCenter;
        StCenter: begin
          if (approaching) begin
            state_d     = StWait;
            react_cnt_d = CntW'(REACT_TICKS);
          end
        end
        StWait: begin
          if (!approaching) begin
            state_d = StCenter;
          end else if (react_cnt_q == '0) begin
            state_d = StTrack;
          end else begin
            react_cnt_d = react_cnt_q - 1'b1;
          end
        end
        StTrack: begin
          if (!approaching) state_d = StCenter;
        end
        default: state_d = StIdle;
      endcase
    end
    // Throttle phase runs only while steering; held at 0 otherwise so the
    // first command after the reaction delay goes out immediately.
    if (state_q == StCenter || state_q == StTrack) begin
      div_cnt_d = (div_cnt_q == DivW'(MOVE_DIV - 1)) ? '0 : div_cnt_q + 1'b1;
    end
  end

  // Output decode.
  always_comb begin
    logic steer;
    steer  = enable && (state_q == StCenter || state_q == StTrack) && (div_cnt_q == '0);
    up_d   = steer && want_up;
    down_d = steer && want_down;
  end

  assign input_up   = up_q;
  assign input_down = down_q;

endmodule

// File: tb/tb_paddle_ai_driver.sv
module tb_paddle_ai_driver;
  import pong_pkg::*;

  logic       game_clk = 1'b0;
  logic       reset, enable, player, ball_dir_left;
  logic [9:0] ball_y, paddle_y;
  logic [7:0] height_paddle;
  logic       up, down, up_d3, down_d3, up_r0, down_r0;

  int checks = 0;
  int errors = 0;

  always #5 game_clk = ~game_clk;

  paddle_ai_driver dut (
    .game_clk      (game_clk),
    .reset         (reset),
    .enable        (enable),
    .player        (player),
    .ball_dir_left (ball_dir_left),
    .ball_y        (ball_y),
    .paddle_y      (paddle_y),
    .height_paddle (height_paddle),
    .input_up      (up),
    .input_down    (down)
  );

  paddle_ai_driver #(
    .MOVE_DIV (3)
  ) dut_div (
    .game_clk      (game_clk),
    .reset         (reset),
    .enable        (enable),
    .player        (player),
    .ball_dir_left (ball_dir_left),
    .ball_y        (ball_y),
    .paddle_y      (paddle_y),
    .height_paddle (height_paddle),
    .input_up      (up_d3),
    .input_down    (down_d3)
  );

  paddle_ai_driver #(
    .REACT_TICKS (0)
  ) dut_r0 (
    .game_clk      (game_clk),
    .reset         (reset),
    .enable        (enable),
    .player        (player),
    .ball_dir_left (ball_dir_left),
    .ball_y        (ball_y),
    .paddle_y      (paddle_y),
    .height_paddle (height_paddle),
    .input_up      (up_r0),
    .input_down    (down_r0)
  );

`ifdef PADDLE_AI_JITTER_EN
  logic [7:0] lfsr_m;
  always @(posedge game_clk) begin
    if (reset) lfsr_m <= 8'hA5;
    else       lfsr_m <= {lfsr_m[6:0], lfsr_m[7] ^ lfsr_m[5] ^ lfsr_m[4] ^ lfsr_m[3]};
  end
`endif

  task automatic tick;
    @(posedge game_clk);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b1; enable = 1'b1; player = 1'b1; ball_dir_left = 1'b0;
    ball_y = 10'd0; paddle_y = 10'd100; height_paddle = 8'd64;
    for (int i = 0; i < 2; i++) begin
      tick;
      checks++;
      if (up !== 1'b0 || down !== 1'b0) begin
        errors++;
        $display("FAIL reset_out[%0d]: up=%b down=%b, want 0 0", i, up, down);
      end
    end
    checks++;
    if (dut.state_q !== StIdle) begin
      errors++;
      $display("FAIL reset_state: got %0d want %0d", dut.state_q, StIdle);
    end
    reset = 1'b0;
    tick;
    checks++;
    if (dut.state_q !== StCenter) begin
      errors++;
      $display("FAIL release_state: got %0d want %0d", dut.state_q, StCenter);
    end
    checks++;
    if (up !== 1'b0 || down !== 1'b0) begin
      errors++;
      $display("FAIL release_out: up=%b down=%b, want 0 0", up, down);
    end
  endtask

  // Receding ball, target 240, pc = paddle_y + 32.
  task automatic test_center;
    logic [9:0] py [4] = '{10'd100, 10'd203, 10'd204, 10'd213};
    logic       eu [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    logic       ed [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 4; i++) begin
      paddle_y = py[i];
      tick;
      checks++;
      if (up !== eu[i] || down !== ed[i]) begin
        errors++;
        $display("FAIL center[%0d] py=%0d: up=%b down=%b, want %b %b",
                 i, py[i], up, down, eu[i], ed[i]);
      end
    end
  endtask

  // Ball turns toward left paddle; 9 quiet cycles of WAIT then TRACK.
  task automatic test_react;
`ifdef PADDLE_AI_JITTER_EN
    logic [5:0] exp_off;
`endif
    paddle_y = 10'd208;  // pc 240: centre target satisfied
    ball_y = 10'd196;    // track target 200 -> err -40
    ball_dir_left = 1'b1;
    tick;
    checks++;
    if (up !== 1'b0 || down !== 1'b0) begin
      errors++;
      $display("FAIL react_e0: up=%b down=%b, want 0 0", up, down);
    end
    for (int i = 1; i <= 9; i++) begin
`ifdef PADDLE_AI_JITTER_EN
      exp_off = {1'b0, lfsr_m[4:0]} - 6'd16;
`endif
      tick;
      checks++;
      if (up !== 1'b0 || down !== 1'b0) begin
        errors++;
        $display("FAIL react_wait[%0d]: up=%b down=%b, want 0 0", i, up, down);
      end
      if (i == 1) begin
        checks++;
        if (up_r0 !== 1'b0 || down_r0 !== 1'b0) begin
          errors++;
          $display("FAIL react0_wait: up=%b down=%b, want 0 0", up_r0, down_r0);
        end
      end
      if (i == 2) begin
        checks++;
        if (up_r0 !== 1'b1 || down_r0 !== 1'b0) begin
          errors++;
          $display("FAIL react0_track: up=%b down=%b, want 1 0", up_r0, down_r0);
        end
      end
`ifdef PADDLE_AI_JITTER_EN
      if (i == 9) begin
        checks++;
        if (dut.offset_q !== $signed(exp_off)) begin
          errors++;
          $display("FAIL jitter_offset: got %0d want %0d", dut.offset_q, $signed(exp_off));
        end
      end
`endif
    end
    tick;
    checks++;
    if (up !== 1'b1 || down !== 1'b0) begin
      errors++;
      $display("FAIL react_track: up=%b down=%b, want 1 0", up, down);
    end
  endtask

`ifndef PADDLE_AI_JITTER_EN
  // Target 200; pc = paddle_y + 32 -> err 5, 4, 0, -4, -5.
  task automatic test_deadzone;
    logic [9:0] py [5] = '{10'd163, 10'd164, 10'd168, 10'd172, 10'd173};
    logic       eu [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    logic       ed [5] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    for (int i = 0; i < 5; i++) begin
      paddle_y = py[i];
      tick;
      checks++;
      if (up !== eu[i] || down !== ed[i]) begin
        errors++;
        $display("FAIL deadzone[%0d] py=%0d: up=%b down=%b, want %b %b",
                 i, py[i], up, down, eu[i], ed[i]);
      end
    end
  endtask
`endif

  // Flip away then back: full dwell again; MOVE_DIV=3 pattern 1,0,0,1,0,0.
  task automatic test_throttle;
    logic pat [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    ball_y = 10'd900;
    paddle_y = 10'd100;
    ball_dir_left = 1'b0;
    tick;
    ball_dir_left = 1'b1;
    tick;
    for (int i = 1; i <= 9; i++) begin
      tick;
      checks++;
      if (up !== 1'b0 || down !== 1'b0) begin
        errors++;
        $display("FAIL redwell[%0d]: up=%b down=%b, want 0 0", i, up, down);
      end
    end
    for (int i = 0; i < 6; i++) begin
      tick;
      checks++;
      if (down_d3 !== pat[i] || up_d3 !== 1'b0) begin
        errors++;
        $display("FAIL throttle[%0d]: up=%b down=%b, want 0 %b", i, up_d3, down_d3, pat[i]);
      end
      checks++;
      if (down !== 1'b1 || up !== 1'b0) begin
        errors++;
        $display("FAIL full_rate[%0d]: up=%b down=%b, want 0 1", i, up, down);
      end
      checks++;
      if (up_r0 === 1'b1 && down_r0 === 1'b1) begin
        errors++;
        $display("FAIL exclusive[%0d]: up=%b down=%b, want not both", i, up_r0, down_r0);
      end
    end
  endtask

  task automatic test_disable;
    enable = 1'b0;
    tick;
    checks++;
    if (up !== 1'b0 || down !== 1'b0 || up_d3 !== 1'b0 || down_d3 !== 1'b0) begin
      errors++;
      $display("FAIL disable_out: up=%b down=%b up3=%b down3=%b, want 0", up, down, up_d3, down_d3);
    end
    checks++;
    if (dut.state_q !== StIdle) begin
      errors++;
      $display("FAIL disable_state: got %0d want %0d", dut.state_q, StIdle);
    end
    enable = 1'b1;
    tick;
    checks++;
    if (dut.state_q !== StCenter) begin
      errors++;
      $display("FAIL reenable_state: got %0d want %0d", dut.state_q, StCenter);
    end
  endtask

  task automatic test_reset_mid_wait;
    tick;  // approaching: CENTER -> WAIT
    tick;
    checks++;
    if (dut.state_q !== StWait) begin
      errors++;
      $display("FAIL mid_wait_state: got %0d want %0d", dut.state_q, StWait);
    end
    reset = 1'b1;
    tick;
    checks++;
    if (dut.state_q !== StIdle || up !== 1'b0 || down !== 1'b0) begin
      errors++;
      $display("FAIL mid_wait_reset: state=%0d up=%b down=%b, want %0d 0 0",
               dut.state_q, up, down, StIdle);
    end
    reset = 1'b0;
    tick;
    checks++;
    if (dut.state_q !== StCenter) begin
      errors++;
      $display("FAIL after_reset_state: got %0d want %0d", dut.state_q, StCenter);
    end
  endtask

  initial begin
    test_reset;
    test_center;
    test_react;
`ifndef PADDLE_AI_JITTER_EN
    test_deadzone;
`endif
    test_throttle;
    test_disable;
    test_reset_mid_wait;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1);
  end

endmodule
